delta_calculator: RTL and testbench

DELTA_CALCULATOR -- requirements
Module: delta_calculator

---
 rtl/digit_pkg.sv | 16 +
 rtl/digit_argmax.sv | 42 ++++
 rtl/delta_calculator.sv | 118 +++++++++++
 tb/tb_delta_calculator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared constants and FSM state type for the digit delta calculator.
// The index width is derived per-instance, so it lives in the modules.
package digit_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int WEIGHT_W   = 4;
    localparam int DELTA_W    = 5;
    localparam int ONE_Q      = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/digit_argmax.sv
// Running-maximum tracker over streamed (index, weight) pairs.
// best_idx_o already includes the update applied in the current cycle.
module digit_argmax #(
    parameter int IDX_W    = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                update_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [WEIGHT_W-1:0] weight_i,
    output logic [IDX_W-1:0]    best_idx_o
);

    logic [IDX_W-1:0]    best_idx_q, best_idx_d;
    logic [WEIGHT_W-1:0] best_w_q, best_w_d;

    // Strict greater-than keeps the earliest (lowest) index on ties; clearing
    // to index 0 / weight 0 is safe because weights are unsigned.
    always_comb begin
        best_idx_d = best_idx_q;
        best_w_d   = best_w_q;
        if (update_i && (weight_i > best_w_q)) begin
            best_idx_d = idx_i;
            best_w_d   = weight_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            best_idx_q <= '0;
            best_w_q   <= '0;
        end else begin
            best_idx_q <= best_idx_d;
            best_w_q   <= best_w_d;
        end
    end

    assign best_idx_o = best_idx_d;

endmodule

// File: rtl/delta_calculator.sv
// Streams per-class error deltas (weight minus one-hot target) to a backprop
// stage with valid/ready handshaking, then reports argmax and label checks.
module delta_calculator #(
    parameter int NUM_DIGITS = digit_pkg::NUM_DIGITS,
    parameter int WEIGHT_W   = digit_pkg::WEIGHT_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 delta_en,
    input  logic [0:NUM_DIGITS-1]                expected_label,
    input  logic [0:NUM_DIGITS-1][WEIGHT_W-1:0]  digit_weights,
    input  logic                                 delta_ready,
    output logic                                 delta_valid,
    output logic [$clog2(NUM_DIGITS)-1:0]        delta_index,
    output logic [digit_pkg::DELTA_W-1:0]        delta_value,
    output logic                                 calculation_complete,
    output logic [$clog2(NUM_DIGITS)-1:0]        predicted_digit,
    output logic                                 prediction_correct,
    output logic                                 label_error
);

    import digit_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                               state_q;
    logic [IDX_W-1:0]                     index_q;
    logic [0:NUM_DIGITS-1]                label_q;
    logic [0:NUM_DIGITS-1][WEIGHT_W-1:0]  weights_q;
    logic [IDX_W-1:0]                     predicted_q;
    logic                                 correct_q;
    logic                                 label_error_q;

    logic                                 start;
    logic                                 transfer;
    logic [IDX_W-1:0]                     best_idx_d;
    logic [WEIGHT_W-1:0]                  cur_weight;
    logic                                 cur_target;
    logic [IDX_W:0]                       ones_d;
    logic                                 one_hot_d;

    assign start      = (state_q == IDLE) && delta_en;
    assign transfer   = (state_q == STREAM) && delta_ready;
    assign cur_weight = weights_q[index_q];
    assign cur_target = label_q[index_q];

    always_comb begin
        ones_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ones_d = ones_d + (IDX_W+1)'(label_q[i]);
        end
        one_hot_d = (ones_d == (IDX_W+1)'(1));
    end

    digit_argmax #(
        .IDX_W    (IDX_W),
        .WEIGHT_W (WEIGHT_W)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (start),
        .update_i   (transfer),
        .idx_i      (index_q),
        .weight_i   (cur_weight),
        .best_idx_o (best_idx_d)
    );

    // Results are latched on the final transfer so they are valid during DONE
    // and then hold until the next run completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            index_q       <= '0;
            label_q       <= '0;
            weights_q     <= '0;
            predicted_q   <= '0;
            correct_q     <= 1'b0;
            label_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (delta_en) begin
                        label_q   <= expected_label;
                        weights_q <= digit_weights;
                        index_q   <= '0;
                        state_q   <= STREAM;
                    end
                end
                STREAM: begin
                    if (delta_ready) begin
                        if (index_q == LAST_IDX) begin
                            state_q       <= DONE;
                            predicted_q   <= best_idx_d;
                            correct_q     <= label_q[best_idx_d];
                            label_error_q <= ~one_hot_d;
                        end else begin
                            index_q <= index_q + 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign delta_valid          = (state_q == STREAM);
    assign calculation_complete = (state_q == DONE);
    assign delta_index          = delta_valid ? index_q : '0;
    assign delta_value          = delta_valid
                                ? DELTA_W'({1'b0, cur_weight}) - (cur_target ? DELTA_W'(ONE_Q) : '0)
                                : '0;
    assign predicted_digit      = predicted_q;
    assign prediction_correct   = correct_q;
    assign label_error          = label_error_q;

endmodule

// File: tb/tb_delta_calculator.sv
// Directed bench for delta_calculator: a table of hand-computed vectors plus
// sequences for backpressure, mid-stream reset and a held start request.
module tb_delta_calculator;

    logic             clk = 1'b0;
    logic             rst;
    logic             delta_en;
    logic [0:9]       expected_label;
    logic [0:9][3:0]  digit_weights;
    logic             delta_ready;
    logic             delta_valid;
    logic [3:0]       delta_index;
    logic [4:0]       delta_value;
    logic             calculation_complete;
    logic [3:0]       predicted_digit;
    logic             prediction_correct;
    logic             label_error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [0:9]       label;
        logic [0:9][3:0]  weights;
        logic [0:9][4:0]  deltas;
        logic [3:0]       pred;
        logic             corr;
        logic             err;
    } vec_t;

    vec_t vecs [6];
    int   readyPat [4] = '{1, 0, 0, 1};

    delta_calculator dut (
        .clk                  (clk),
        .rst                  (rst),
        .delta_en             (delta_en),
        .expected_label       (expected_label),
        .digit_weights        (digit_weights),
        .delta_ready          (delta_ready),
        .delta_valid          (delta_valid),
        .delta_index          (delta_index),
        .delta_value          (delta_value),
        .calculation_complete (calculation_complete),
        .predicted_digit      (predicted_digit),
        .prediction_correct   (prediction_correct),
        .label_error          (label_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t makeVec(input logic [0:9] lbl, input int w [10], input int d [10],
                                     input int p, input int c, input int e);
        vec_t v;
        v.label = lbl;
        for (int i = 0; i < 10; i++) begin
            v.weights[i] = 4'(w[i]);
            v.deltas[i]  = 5'(d[i]);
        end
        v.pred = 4'(p);
        v.corr = 1'(c);
        v.err  = 1'(e);
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int v);
        expected_label = vecs[v].label;
        digit_weights  = vecs[v].weights;
        delta_en       = 1'b1;
        nextCycle();
        delta_en       = 1'b0;
    endtask

    // Expects to be called on the first STREAM cycle of vector v.
    task automatic checkStream(input int v);
        delta_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("v%0d.valid%0d", v, i), int'(delta_valid), 1);
            checkOutput($sformatf("v%0d.index%0d", v, i), int'(delta_index), i);
            checkOutput($sformatf("v%0d.value%0d", v, i), int'($signed(delta_value)),
                        int'($signed(vecs[v].deltas[i])));
            checkOutput($sformatf("v%0d.cplLow%0d", v, i), int'(calculation_complete), 0);
            nextCycle();
        end
        checkOutput($sformatf("v%0d.complete", v), int'(calculation_complete), 1);
        checkOutput($sformatf("v%0d.validDone", v), int'(delta_valid), 0);
        checkOutput($sformatf("v%0d.pred", v), int'(predicted_digit), int'(vecs[v].pred));
        checkOutput($sformatf("v%0d.correct", v), int'(prediction_correct), int'(vecs[v].corr));
        checkOutput($sformatf("v%0d.labelErr", v), int'(label_error), int'(vecs[v].err));
        nextCycle();
        checkOutput($sformatf("v%0d.cplOnce", v), int'(calculation_complete), 0);
        checkOutput($sformatf("v%0d.predHeld", v), int'(predicted_digit), int'(vecs[v].pred));
    endtask

    initial begin
        int w [10];
        int d [10];
        int expIdx;
        int cyc;
        logic rdy;

        rst            = 1'b1;
        delta_en       = 1'b0;
        delta_ready    = 1'b0;
        expected_label = '0;
        digit_weights  = '0;

        // Label literals are [0:9]: the leftmost bit is class 0.
        w = '{0, 0, 0, 8, 0, 0, 0, 0, 0, 0};
        d = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[0] = makeVec(10'b0001000000, w, d, 3, 1, 0);
        w = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        d = '{-6, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        vecs[1] = makeVec(10'b1000000000, w, d, 9, 0, 0);
        w = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        d = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        vecs[2] = makeVec(10'b0000000000, w, d, 0, 0, 1);
        w = '{15, 0, 8, 3, 15, 1, 2, 8, 0, 4};
        d = '{15, 0, 0, 3, 15, 1, 2, 0, 0, 4};
        vecs[3] = makeVec(10'b0010000100, w, d, 0, 0, 1);
        w = '{14, 14, 14, 14, 14, 14, 14, 14, 14, 15};
        d = '{14, 14, 14, 14, 14, 14, 14, 14, 14, 7};
        vecs[4] = makeVec(10'b0000000001, w, d, 9, 1, 0);
        w = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        d = '{0, 0, 0, 0, 0, -8, 0, 0, 0, 0};
        vecs[5] = makeVec(10'b0000010000, w, d, 0, 0, 0);

        nextCycle();
        nextCycle();
        checkOutput("rst.valid", int'(delta_valid), 0);
        checkOutput("rst.index", int'(delta_index), 0);
        checkOutput("rst.value", int'(delta_value), 0);
        checkOutput("rst.complete", int'(calculation_complete), 0);
        checkOutput("rst.pred", int'(predicted_digit), 0);
        checkOutput("rst.correct", int'(prediction_correct), 0);
        checkOutput("rst.labelErr", int'(label_error), 0);
        rst = 1'b0;
        nextCycle();

        for (int v = 0; v < 6; v++) begin
            applyStimulus(v);
            checkStream(v);
        end

        // Backpressure with ready pattern 1,0,0,1 repeating.
        applyStimulus(1);
        expIdx = 0;
        cyc    = 0;
        while (expIdx < 10 && cyc < 80) begin
            rdy         = readyPat[cyc % 4] != 0;
            delta_ready = rdy;
            checkOutput($sformatf("bp.valid%0d", cyc), int'(delta_valid), 1);
            checkOutput($sformatf("bp.index%0d", cyc), int'(delta_index), expIdx);
            checkOutput($sformatf("bp.value%0d", cyc), int'($signed(delta_value)),
                        int'($signed(vecs[1].deltas[expIdx])));
            nextCycle();
            if (rdy) expIdx++;
            cyc++;
        end
        checkOutput("bp.allSeen", expIdx, 10);
        checkOutput("bp.complete", int'(calculation_complete), 1);
        checkOutput("bp.pred", int'(predicted_digit), 9);
        nextCycle();
        checkOutput("bp.cplOnce", int'(calculation_complete), 0);

        // Reset two cycles mid-stream, then a start held through reset.
        applyStimulus(1);
        delta_ready = 1'b1;
        nextCycle();
        nextCycle();
        nextCycle();
        rst = 1'b1;
        nextCycle();
        checkOutput("mid.valid", int'(delta_valid), 0);
        checkOutput("mid.index", int'(delta_index), 0);
        checkOutput("mid.value", int'(delta_value), 0);
        checkOutput("mid.complete", int'(calculation_complete), 0);
        checkOutput("mid.pred", int'(predicted_digit), 0);
        checkOutput("mid.correct", int'(prediction_correct), 0);
        checkOutput("mid.labelErr", int'(label_error), 0);
        expected_label = vecs[0].label;
        digit_weights  = vecs[0].weights;
        delta_en       = 1'b1;
        nextCycle();
        checkOutput("mid.rstPrio", int'(delta_valid), 0);
        checkOutput("mid.complete2", int'(calculation_complete), 0);
        rst = 1'b0;
        nextCycle();
        delta_en = 1'b0;
        checkStream(0);

        // Start held high while inputs change: only the first capture counts.
        expected_label = vecs[0].label;
        digit_weights  = vecs[0].weights;
        delta_en       = 1'b1;
        nextCycle();
        for (int i = 0; i < 10; i++) begin
            expected_label = vecs[2 + (i % 2)].label;
            digit_weights  = vecs[2 + (i % 2)].weights;
            checkOutput($sformatf("hold.index%0d", i), int'(delta_index), i);
            checkOutput($sformatf("hold.value%0d", i), int'($signed(delta_value)),
                        int'($signed(vecs[0].deltas[i])));
            nextCycle();
        end
        checkOutput("hold.complete", int'(calculation_complete), 1);
        checkOutput("hold.pred", int'(predicted_digit), 3);
        checkOutput("hold.correct", int'(prediction_correct), 1);
        expected_label = vecs[2].label;
        digit_weights  = vecs[2].weights;
        nextCycle();
        checkOutput("hold.idleValid", int'(delta_valid), 0);
        checkOutput("hold.idleCpl", int'(calculation_complete), 0);
        nextCycle();
        delta_en = 1'b0;
        checkStream(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
